// File: rtl/xor_cipher_ctrl_pkg.sv
// Shared definitions for the XOR cipher sequencing controller: state
// encoding, default key/word geometry and the key-ready timeout.
package xor_cipher_ctrl_pkg;

  localparam int unsigned DEF_KEY_BITS     = 512;
  localparam int unsigned DEF_WORD_BITS    = 32;
  localparam int unsigned WAIT_KEY_TIMEOUT = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_WAIT_KEY = 3'd3,
    ST_ENCRYPT  = 3'd4
  } state_t;

endpackage

// File: rtl/xor_cipher_ctrl.sv
// Serial key packer, assembler sequencing and XOR encrypt stage.
// Optional re-key support is enabled with `define CIPHER_CTRL_REKEY_EN.
module xor_cipher_ctrl
  import xor_cipher_ctrl_pkg::*;
#(
  parameter int unsigned KEY_BITS  = DEF_KEY_BITS,
  parameter int unsigned WORD_BITS = DEF_WORD_BITS
) (
  input  logic                           iClk,
  input  logic                           iRst,
  input  logic                           iStart,
  input  logic                           iStop,
  input  logic                           iRekey,
  input  logic                           iBit,
  input  logic                           iBit_valid,
  output logic                           oBit_ready,
  output logic [WORD_BITS-1:0]           oKey_word,
  output logic [$clog2(WORD_BITS):0]     oBit_counter_key,
  input  logic                           iCan_encrypt,
  input  logic [KEY_BITS-1:0]            iAssembled_key,
  output logic                           oAsm_rst_n,
  output logic                           oCipher_bit,
  output logic                           oCipher_valid,
  output logic [$clog2(KEY_BITS)-1:0]    oKey_ptr,
  output logic [2:0]                     oState,
  output logic                           oKey_loaded,
  output logic                           oError
);

  localparam int unsigned CW  = $clog2(WORD_BITS) + 1;
  localparam int unsigned PW  = $clog2(KEY_BITS);
  localparam int unsigned NW  = KEY_BITS / WORD_BITS;
  localparam int unsigned WCW = $clog2(NW) + 1;
  localparam int unsigned TW  = $clog2(WAIT_KEY_TIMEOUT);

  state_t               state, state_n;
  logic [CW-1:0]        bit_cnt, bit_cnt_n;
  logic [WCW-1:0]       word_cnt, word_cnt_n;
  logic [TW-1:0]        tmo_cnt, tmo_cnt_n;
  logic [WORD_BITS-1:0] key_word, key_word_n;
  logic [PW-1:0]        key_ptr, key_ptr_n;
  logic                 cipher_bit, cipher_bit_n;
  logic                 cipher_valid, cipher_valid_n;
  logic                 key_loaded, key_loaded_n;
  logic                 error, error_n;
  logic                 asm_rst_n, asm_rst_n_n;
  logic                 bit_ready;
  logic                 accept;
  logic                 rekey_req;

`ifdef CIPHER_CTRL_REKEY_EN
  assign rekey_req = iRekey;
`else
  logic rekey_unused;
  assign rekey_unused = iRekey;
  assign rekey_req    = 1'b0;
`endif

  // The strobe cycle (counter at WORD_BITS) is the only LOAD bubble.
  assign bit_ready = (state == ST_ENCRYPT) ||
                     ((state == ST_LOAD) && (bit_cnt != CW'(WORD_BITS)));
  assign accept    = iBit_valid && bit_ready;

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      bit_cnt      <= '0;
      word_cnt     <= '0;
      tmo_cnt      <= '0;
      key_word     <= '0;
      key_ptr      <= '0;
      cipher_bit   <= 1'b0;
      cipher_valid <= 1'b0;
      key_loaded   <= 1'b0;
      error        <= 1'b0;
      asm_rst_n    <= 1'b1;
    end else begin
      bit_cnt      <= bit_cnt_n;
      word_cnt     <= word_cnt_n;
      tmo_cnt      <= tmo_cnt_n;
      key_word     <= key_word_n;
      key_ptr      <= key_ptr_n;
      cipher_bit   <= cipher_bit_n;
      cipher_valid <= cipher_valid_n;
      key_loaded   <= key_loaded_n;
      error        <= error_n;
      asm_rst_n    <= asm_rst_n_n;
    end
  end

  always_comb begin
    state_n        = state;
    bit_cnt_n      = bit_cnt;
    word_cnt_n     = word_cnt;
    tmo_cnt_n      = tmo_cnt;
    key_word_n     = key_word;
    key_ptr_n      = key_ptr;
    cipher_bit_n   = cipher_bit;
    cipher_valid_n = 1'b0;
    key_loaded_n   = key_loaded;
    error_n        = error;
    asm_rst_n_n    = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (rekey_req) begin
          asm_rst_n_n  = 1'b0;
          key_loaded_n = 1'b0;
          word_cnt_n   = '0;
          bit_cnt_n    = '0;
          state_n      = ST_LOAD;
        end else if (iStart) begin
          if (key_loaded) begin
            key_ptr_n = '0;
            state_n   = ST_ENCRYPT;
          end else begin
            word_cnt_n = '0;
            bit_cnt_n  = '0;
            error_n    = 1'b0;
            state_n    = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (bit_cnt == CW'(WORD_BITS)) begin
          word_cnt_n = word_cnt + WCW'(1);
          // After the last word the counter stays at WORD_BITS so FLUSH
          // presents a second, back-to-back strobe.
          if (word_cnt == WCW'(NW - 1)) begin
            state_n = ST_FLUSH;
          end else begin
            bit_cnt_n = '0;
          end
        end else if (accept) begin
          key_word_n[bit_cnt[CW-2:0]] = iBit;
          bit_cnt_n                   = bit_cnt + CW'(1);
        end
      end

      ST_FLUSH: begin
        bit_cnt_n = '0;
        tmo_cnt_n = '0;
        state_n   = ST_WAIT_KEY;
      end

      ST_WAIT_KEY: begin
        if (iCan_encrypt) begin
          key_loaded_n = 1'b1;
          key_ptr_n    = '0;
          tmo_cnt_n    = '0;
          state_n      = ST_ENCRYPT;
        end else if (tmo_cnt == TW'(WAIT_KEY_TIMEOUT - 1)) begin
          error_n   = 1'b1;
          tmo_cnt_n = '0;
          state_n   = ST_IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + TW'(1);
        end
      end

      ST_ENCRYPT: begin
        if (accept) begin
          cipher_bit_n   = iBit ^ iAssembled_key[key_ptr];
          cipher_valid_n = 1'b1;
          key_ptr_n      = (key_ptr == PW'(KEY_BITS - 1)) ? '0 : key_ptr + PW'(1);
        end
        if (rekey_req) begin
          asm_rst_n_n  = 1'b0;
          key_loaded_n = 1'b0;
          word_cnt_n   = '0;
          bit_cnt_n    = '0;
          state_n      = ST_LOAD;
        end else if (iStop) begin
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign oBit_ready       = bit_ready;
  assign oKey_word        = key_word;
  assign oBit_counter_key = bit_cnt;
  assign oAsm_rst_n       = asm_rst_n;
  assign oCipher_bit      = cipher_bit;
  assign oCipher_valid    = cipher_valid;
  assign oKey_ptr         = key_ptr;
  assign oState           = state;
  assign oKey_loaded      = key_loaded;
  assign oError           = error;

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Scoreboard bench for xor_cipher_ctrl with a behavioural key assembler;
// expected ciphertext comes from the key bits the bench itself sent.
module tb_xor_cipher_ctrl;

  localparam int KB = 512;
  localparam int WB = 32;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic          iStart = 1'b0, iStop = 1'b0, iRekey = 1'b0;
  logic          iBit = 1'b0, iBit_valid = 1'b0;
  logic          oBit_ready;
  logic [WB-1:0] oKey_word;
  logic [5:0]    oBit_counter_key;
  logic          iCan_encrypt;
  logic [KB-1:0] iAssembled_key;
  logic          oAsm_rst_n, oCipher_bit, oCipher_valid;
  logic [8:0]    oKey_ptr;
  logic [2:0]    oState;
  logic          oKey_loaded, oError;

  xor_cipher_ctrl #(.KEY_BITS(KB), .WORD_BITS(WB)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iStop(iStop), .iRekey(iRekey),
    .iBit(iBit), .iBit_valid(iBit_valid), .oBit_ready(oBit_ready),
    .oKey_word(oKey_word), .oBit_counter_key(oBit_counter_key),
    .iCan_encrypt(iCan_encrypt), .iAssembled_key(iAssembled_key),
    .oAsm_rst_n(oAsm_rst_n), .oCipher_bit(oCipher_bit),
    .oCipher_valid(oCipher_valid), .oKey_ptr(oKey_ptr), .oState(oState),
    .oKey_loaded(oKey_loaded), .oError(oError)
  );

  always #5 iClk = ~iClk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge iClk) cyc <= cyc + 1;

  // Behavioural assembler: stores KB/WB words on strobes, then raises
  // the ready flag on the next strobe when allowed to.
  logic [KB-1:0] asm_key;
  int            asm_words;
  logic          asm_can;
  logic          asm_can_en = 1'b1;
  always @(posedge iClk) begin
    if (!iRst || !oAsm_rst_n) begin
      asm_key <= '0; asm_words <= 0; asm_can <= 1'b0;
    end else if (oBit_counter_key == 6'd32) begin
      if (asm_words < KB / WB) begin
        asm_key[asm_words*WB +: WB] <= oKey_word;
        asm_words <= asm_words + 1;
      end else if (asm_can_en) begin
        asm_can <= 1'b1;
      end
    end
  end
  assign iAssembled_key = asm_key;
  assign iCan_encrypt   = asm_can;

  int   strobes = 0, doubles = 0;
  logic prev_strobe = 1'b0;
  always @(negedge iClk) begin
    if (iRst) begin
      if (oBit_counter_key == 6'd32) begin
        strobes++;
        if (prev_strobe) doubles++;
        prev_strobe = 1'b1;
      end else begin
        prev_strobe = 1'b0;
      end
    end
  end

  // Reference model: key bits as sent, and a wrapping pointer.
  typedef struct { logic cbit; int cyc; } exp_t;
  exp_t          exp_q[$];
  logic [KB-1:0] ref_key;
  int            load_idx;
  int            ptr_m;
  bit            enc_phase;

  always @(negedge iClk) begin
    if (iRst && oCipher_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cipher_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cipher_bit", oCipher_bit, e.cbit);
        check("cipher_latency", cyc, e.cyc + 1);
      end
    end
  end

  task automatic send_bit(input logic b);
    int n;
    iBit = b; iBit_valid = 1'b1; n = 0;
    while (!oBit_ready && n < 8) begin @(negedge iClk); n++; end
    if (!oBit_ready) begin
      check("bit_ready_timeout", 64'd0, 64'd1);
    end else begin
      if (enc_phase) begin
        check("key_ptr", oKey_ptr, ptr_m);
        exp_q.push_back('{cbit: b ^ ref_key[ptr_m], cyc: cyc});
        ptr_m = (ptr_m + 1) % KB;
      end else begin
        ref_key[load_idx] = b;
        load_idx++;
      end
      @(negedge iClk);
    end
    iBit_valid = 1'b0;
  endtask

  task automatic pulse_start();
    iStart = 1'b1; @(negedge iClk); iStart = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (oState != s && n < budget) begin @(negedge iClk); n++; end
    check(name, oState, s);
  endtask

  task automatic load_key(input bit alternating);
    strobes = 0; doubles = 0; load_idx = 0; enc_phase = 0;
    for (int i = 0; i < KB; i++) send_bit(alternating ? ((i % 2) == 0) : 1'($urandom));
  endtask

  task automatic do_reset();
    iRst = 1'b0;
    repeat (3) @(negedge iClk);
    iRst = 1'b1;
    enc_phase = 0; ptr_m = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge iClk);
    do_reset();
    check("rst_state", oState, 3'd0);
    check("rst_ready", oBit_ready, 1'b0);
    check("rst_loaded", oKey_loaded, 1'b0);
    check("rst_error", oError, 1'b0);
    check("rst_asm_rst_n", oAsm_rst_n, 1'b1);
    check("rst_counter", oBit_counter_key, 6'd0);
    check("rst_ptr", oKey_ptr, 9'd0);
    check("rst_cipher_valid", oCipher_valid, 1'b0);

    // Alternating key load
    pulse_start();
    check("load_state", oState, 3'd1);
    load_key(1'b1);
    wait_state(3'd4, 40, "enter_encrypt");
    check("key_loaded", oKey_loaded, 1'b1);
    check("strobe_count", strobes, 17);
    check("double_strobes", doubles, 1);
    check("assembled_key", asm_key == ref_key, 1'b1);
    check("ref_key_pattern", ref_key[63:0], 64'h5555555555555555);

    // Eight ones against 0x5555... key
    enc_phase = 1; ptr_m = 0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);

    // Stop with a bit in the same cycle, then re-enter without reload
    iStop = 1'b1;
    send_bit(1'($urandom));
    iStop = 1'b0;
    check("stop_state", oState, 3'd0);
    check("stop_ptr_held", oKey_ptr, 9'd9);
    pulse_start();
    check("reenter_state", oState, 3'd4);
    check("reenter_ptr", oKey_ptr, 9'd0);
    check("reenter_loaded", oKey_loaded, 1'b1);
    ptr_m = 0;

    // Wrap the key pointer
    for (int i = 0; i < KB + 2; i++) send_bit(1'($urandom));
    check("wrap_ptr", oKey_ptr, 9'd2);

    // Re-key request while encrypting
    iRekey = 1'b1; @(negedge iClk); iRekey = 1'b0;
`ifdef CIPHER_CTRL_REKEY_EN
    check("rekey_asm_rst_low", oAsm_rst_n, 1'b0);
    check("rekey_loaded", oKey_loaded, 1'b0);
    check("rekey_state", oState, 3'd1);
    @(negedge iClk);
    check("rekey_asm_rst_high", oAsm_rst_n, 1'b1);
    load_key(1'b0);
    wait_state(3'd4, 40, "rekey_encrypt");
    check("rekey_assembled_key", asm_key == ref_key, 1'b1);
    enc_phase = 1; ptr_m = 0;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom));
`else
    check("norekey_asm_rst", oAsm_rst_n, 1'b1);
    check("norekey_loaded", oKey_loaded, 1'b1);
    check("norekey_state", oState, 3'd4);
`endif
    repeat (2) @(negedge iClk);

    // Key-ready timeout
    do_reset();
    asm_can_en = 1'b0;
    pulse_start();
    load_key(1'b0);
    wait_state(3'd3, 40, "enter_wait_key");
    begin
      int n = 0;
      while (oState == 3'd3 && n < 20) begin @(negedge iClk); n++; end
      check("wait_key_cycles", n, 8);
    end
    check("timeout_state", oState, 3'd0);
    check("timeout_error", oError, 1'b1);
    check("timeout_loaded", oKey_loaded, 1'b0);
    pulse_start();
    check("restart_state", oState, 3'd1);
    check("restart_error_clr", oError, 1'b0);

    repeat (2) @(negedge iClk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xor_cipher_ctrl.md
# xor_cipher_ctrl

Sequencing controller for the XOR cipher datapath. It takes one serial input bit stream, packs the key phase into 32-bit words and drives the key assembler's word and bit-count inputs. It then issues the extra strobe the assembler needs to raise its encrypt-ready flag. In the encrypt phase it XORs each further serial bit with the assembled 512-bit key, walking a wrapping key pointer.

## Interface
Parameters:
- KEY_BITS, 512, assembled key width; must be a multiple of WORD_BITS.
- WORD_BITS, 32, width of one key word.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  reset, synchronous, active-low.
- iStart  in  1  one-cycle pulse; begins a key load, or begins encryption when a key is already loaded.
- iStop  in  1  one-cycle pulse; leaves ENCRYPT for IDLE.
- iRekey  in  1  one-cycle pulse; discards the loaded key (only with CIPHER_CTRL_REKEY_EN).
- iBit  in  1  serial data bit.
- iBit_valid  in  1  iBit is valid; a bit is accepted when iBit_valid && oBit_ready.
- oBit_ready  out  1  controller can accept a bit this cycle.
- oKey_word  out  WORD_BITS  packed key word, to the assembler key input.
- oBit_counter_key  out  $clog2(WORD_BITS)+1  bits packed so far; equals WORD_BITS for exactly one cycle per word strobe.
- iCan_encrypt  in  1  assembler encrypt-ready flag.
- iAssembled_key  in  KEY_BITS  assembler key output.
- oAsm_rst_n  out  1  assembler reset request, active-low.
- oCipher_bit  out  1  ciphertext bit.
- oCipher_valid  out  1  oCipher_bit is valid.
- oKey_ptr  out  $clog2(KEY_BITS)  key bit index used for the next encrypted bit.
- oState  out  3  current FSM state encoding.
- oKey_loaded  out  1  a complete key is held by the assembler.
- oError  out  1  sticky; set on key-ready timeout.

## Operation
- States: IDLE=0, LOAD=1, FLUSH=2, WAIT_KEY=3, ENCRYPT=4.
- IDLE
  - oBit_ready=0.
  - iStart with oKey_loaded=0: go to LOAD, clear word count and oError.
  - iStart with oKey_loaded=1: go to ENCRYPT with oKey_ptr=0.
- LOAD
  - oBit_ready=1 except in the strobe cycle, when oBit_counter_key==WORD_BITS.
  - Each accepted bit is written to oKey_word[oBit_counter_key], LSB first, and the counter increments.
  - The bit that brings the count to WORD_BITS makes the next cycle the strobe cycle.
  - In the strobe cycle the word count increments; the following cycle the counter returns to 0.
  - After the strobe of word KEY_BITS/WORD_BITS (16 by default), go to FLUSH.
- FLUSH
  - Drives oBit_counter_key=WORD_BITS for one more cycle with oKey_word unchanged.
  - The assembler raises iCan_encrypt only on a strobe seen after all words are stored; this extra strobe supplies it.
  - Then go to WAIT_KEY, counter=0.
- WAIT_KEY
  - A timeout counter runs.
  - iCan_encrypt=1: set oKey_loaded, go to ENCRYPT, oKey_ptr=0.
  - 8 cycles without iCan_encrypt: set oError, go to IDLE.
- ENCRYPT
  - oBit_ready=1.
  - Each accepted bit registers oCipher_bit = iBit ^ iAssembled_key[oKey_ptr], with oCipher_valid=1 on the next cycle.
  - oKey_ptr increments modulo KEY_BITS, wrapping 511→0.
  - iStop: go to IDLE. A bit accepted in the same cycle is still encrypted. oKey_ptr is held.
- iStart is ignored outside IDLE. iStop is ignored outside ENCRYPT.
- Reset values:
  - state IDLE.
  - All counters, oKey_word, oBit_counter_key, oCipher_bit, oCipher_valid, oKey_ptr, oKey_loaded and oError: 0.
  - oAsm_rst_n=1.
- Reset asserted mid-LOAD discards the partial key. The assembler must be reset by the system reset in the same cycle.

## Timing
- Key load: 16×32 accepted bits plus 16 strobe cycles plus 1 FLUSH cycle, then WAIT_KEY.
- Encrypt latency: 1 cycle from bit acceptance to oCipher_valid.
- Throughput: 1 bit per cycle, with no bubbles in ENCRYPT.
- oBit_counter_key never holds WORD_BITS for two consecutive cycles, except for the last word strobe followed by the FLUSH strobe.

## Configuration
- CIPHER_CTRL_REKEY_EN defined:
  - iRekey in IDLE or ENCRYPT drives oAsm_rst_n=0 for exactly one cycle.
  - It clears oKey_loaded and enters LOAD on the following cycle.
  - iRekey takes priority over iStop and iStart in the same cycle.
- Undefined:
  - iRekey is ignored and oAsm_rst_n is constant 1.
  - A key, once loaded, persists until iRst.

## Structure
- Shared package: state encoding constants, default KEY_BITS/WORD_BITS, WAIT_KEY timeout value (8).
- No sub-module is needed; the serial packer and XOR stage stay inline in the FSM module.

## Test plan
- Reset, then iStart and 512 bits of alternating pattern (key word 0x55555555) → 16 strobes, 1 FLUSH strobe; a bench assembler raises iCan_encrypt → oState=4, oKey_loaded=1.
- In ENCRYPT, send 8 bits all 1 with key 0x55555555… → ciphertext bits 0,1,0,1,0,1,0,1, each valid 1 cycle after acceptance.
- Send 514 bits in ENCRYPT → oKey_ptr wraps 511→0 and then reads 2; the key bit used after the wrap is iAssembled_key[0].
- Assembler model never raises iCan_encrypt → after 8 WAIT_KEY cycles oError=1 and oState=0; a later iStart clears oError.
- iStop together with a valid bit, then iStart → that bit is encrypted; re-entry to ENCRYPT without reloading, oKey_ptr=0.
- With CIPHER_CTRL_REKEY_EN: iRekey during ENCRYPT → oAsm_rst_n low 1 cycle, oKey_loaded=0, oState=1. Without the macro → no effect.
